// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: shared definitions for the write-back/commit stage.
// CP0 register numbers, cp0Op and regToMul encodings, ExcCode values and
// Status/Cause bit positions.
package wb_commit_pkg;

  // CP0 register numbers (select must be 0)
  localparam logic [4:0] Cp0Count   = 5'd9;
  localparam logic [4:0] Cp0Compare = 5'd11;
  localparam logic [4:0] Cp0Status  = 5'd12;
  localparam logic [4:0] Cp0Cause   = 5'd13;
  localparam logic [4:0] Cp0Epc     = 5'd14;

  typedef enum logic [2:0] {
    Cp0OpNone    = 3'b000,
    Cp0OpMfc0    = 3'b001,
    Cp0OpMtc0    = 3'b010,
    Cp0OpSyscall = 3'b011,
    Cp0OpEret    = 3'b100,
    Cp0OpBreak   = 3'b101
  } cp0_op_e;

  typedef enum logic [1:0] {
    RegToMulNone = 2'b00,
    RegToMulHi   = 2'b01,
    RegToMulLo   = 2'b10,
    RegToMulBoth = 2'b11
  } reg_to_mul_e;

  localparam logic [4:0] ExcInt = 5'd0;
  localparam logic [4:0] ExcSys = 5'd8;
  localparam logic [4:0] ExcBp  = 5'd9;

  // Status / Cause bit positions
  localparam int unsigned StatusIe  = 0;
  localparam int unsigned StatusExl = 1;
  localparam int unsigned StatusBev = 22;
  localparam int unsigned CauseIp7  = 15;
  localparam int unsigned CauseTi   = 30;

  localparam logic [31:0] StatusReset = 32'h0040_0000;

endpackage

// File: rtl/wb_commit_if.sv
// wb_commit_if: MEM/WB pipeline-register outputs (wr_*) toward the commit
// stage, plus the register-file write port and flush/redirect coming back.
// Modports: master = pipeline side, slave = wb_commit.
interface wb_commit_if;
  logic        wr_valid;
  logic [31:0] wr_dout;
  logic [31:0] wr_alu_result;
  logic [4:0]  wr_Rw;
  logic        wr_RegWr;
  logic        wr_MemtoReg;
  logic [31:0] wr_busA;
  logic [63:0] wr_mul_result;
  logic [1:0]  wr_regToMul;
  logic        wr_mulToReg;
  logic        wr_mulRead;
  logic [4:0]  wr_cs;
  logic [2:0]  wr_sel;
  logic [31:0] wr_busB;
  logic [2:0]  wr_cp0Op;
  logic [29:0] wr_PC;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        exc_flush;
  logic [29:0] exc_pc;

  modport master (
    output wr_valid, wr_dout, wr_alu_result, wr_Rw, wr_RegWr, wr_MemtoReg, wr_busA,
           wr_mul_result, wr_regToMul, wr_mulToReg, wr_mulRead, wr_cs, wr_sel, wr_busB,
           wr_cp0Op, wr_PC,
    input  rf_we, rf_waddr, rf_wdata, exc_flush, exc_pc
  );

  modport slave (
    input  wr_valid, wr_dout, wr_alu_result, wr_Rw, wr_RegWr, wr_MemtoReg, wr_busA,
           wr_mul_result, wr_regToMul, wr_mulToReg, wr_mulRead, wr_cs, wr_sel, wr_busB,
           wr_cp0Op, wr_PC,
    output rf_we, rf_waddr, rf_wdata, exc_flush, exc_pc
  );
endinterface

// File: rtl/wb_commit_cp0_regs.sv
// wb_commit_cp0_regs: CP0 subset (Status, Cause, EPC, optional Count/Compare).
// Macro TIMER_INT_EN compiles in Count/Compare and the timer interrupt;
// without it Count/Compare read 0 and TI/IP7 stay 0.
// Ports: clk_i/reset_i (sync, active-high); exc_entry_i/exc_code_i/pc_i for
// exception entry; eret_i; mtc0_we_i/cs_i/sel_i/wdata_i for reads and MTC0;
// rdata_o read mux; epc_pc_o = EPC[31:2]; int_pending_o = unmasked interrupt.
module wb_commit_cp0_regs
  import wb_commit_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        exc_entry_i,
  input  logic [4:0]  exc_code_i,
  input  logic [29:0] pc_i,
  input  logic        eret_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  cs_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [29:0] epc_pc_o,
  output logic        int_pending_o
);

  logic [7:0]  im_q;
  logic        exl_q, ie_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic        ti, ip7;
  logic        sel_ok;

  assign sel_ok = (sel_i == 3'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else if (exc_entry_i) begin
      // Nested exceptions keep the original return address
      if (!exl_q) epc_q <= {pc_i, 2'b00};
      exl_q      <= 1'b1;
      exc_code_q <= exc_code_i;
    end else if (eret_i) begin
      exl_q <= 1'b0;
    end else if (mtc0_we_i && sel_ok) begin
      case (cs_i)
        Cp0Status: begin
          im_q  <= wdata_i[15:8];
          exl_q <= wdata_i[StatusExl];
          ie_q  <= wdata_i[StatusIe];
        end
        Cp0Cause: ip_sw_q <= wdata_i[9:8];
        Cp0Epc:   epc_q   <= wdata_i;
        default: ;
      endcase
    end
  end

`ifdef TIMER_INT_EN
  logic [31:0] count_q, compare_q, count_inc;
  logic        toggle_q, ti_q, ip7_q;

  assign count_inc = count_q + 32'd1;

  // Later assignments give MTC0 priority over the hardware tick/match
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
      ip7_q     <= 1'b0;
    end else begin
      toggle_q <= ~toggle_q;
      if (toggle_q) begin
        count_q <= count_inc;
        if (count_inc == compare_q) begin
          ti_q  <= 1'b1;
          ip7_q <= 1'b1;
        end
      end
      if (mtc0_we_i && sel_ok && cs_i == Cp0Count) begin
        count_q  <= wdata_i;
        toggle_q <= 1'b0;
      end
      if (mtc0_we_i && sel_ok && cs_i == Cp0Compare) begin
        compare_q <= wdata_i;
        ti_q      <= 1'b0;
        ip7_q     <= 1'b0;
      end
    end
  end

  assign ti  = ti_q;
  assign ip7 = ip7_q;
`else
  assign ti  = 1'b0;
  assign ip7 = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    if (sel_ok) begin
      case (cs_i)
`ifdef TIMER_INT_EN
        Cp0Count:   rdata_o = count_q;
        Cp0Compare: rdata_o = compare_q;
`endif
        Cp0Status:  rdata_o = StatusReset | {16'b0, im_q, 6'b0, exl_q, ie_q};
        Cp0Cause:   rdata_o = {1'b0, ti, 14'b0, ip7, 5'b0, ip_sw_q, 1'b0, exc_code_q, 2'b00};
        Cp0Epc:     rdata_o = epc_q;
        default:    rdata_o = '0;
      endcase
    end
  end

  assign epc_pc_o      = epc_q[31:2];
  assign int_pending_o = ie_q & ~exl_q & im_q[7] & ip7;

endmodule

// File: rtl/wb_commit.sv
// wb_commit: write-back/commit stage. Drives the GPR write port, owns HI/LO,
// resolves event priority (interrupt > SYSCALL/BREAK > ERET) and raises the
// flush/redirect. Optional macro TIMER_INT_EN enables the CP0 timer.
// Ports: Clk, Reset (sync, active-high); bus (wb_commit_if.slave) carrying
// the wr_* inputs and rf_we/rf_waddr/rf_wdata/exc_flush/exc_pc outputs.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        Clk,
  input  logic        Reset,
  wb_commit_if.slave  bus
);

  logic [31:0] hi_q, lo_q;
  logic [31:0] cp0_rdata;
  logic [29:0] epc_pc;
  logic        int_pending, int_take, commit, sys_brk, eret, exc_entry, mtc0_we;
  logic [4:0]  exc_code;

  assign int_take  = bus.wr_valid & int_pending;
  // An interrupted instruction commits nothing
  assign commit    = bus.wr_valid & ~int_take;
  assign sys_brk   = commit & (bus.wr_cp0Op == Cp0OpSyscall || bus.wr_cp0Op == Cp0OpBreak);
  assign eret      = commit & ~sys_brk & (bus.wr_cp0Op == Cp0OpEret);
  assign exc_entry = int_take | sys_brk;
  assign mtc0_we   = commit & (bus.wr_cp0Op == Cp0OpMtc0);

  always_comb begin
    exc_code = ExcSys;
    if (int_take) exc_code = ExcInt;
    else if (bus.wr_cp0Op == Cp0OpBreak) exc_code = ExcBp;
  end

  wb_commit_cp0_regs u_cp0 (
    .clk_i         (Clk),
    .reset_i       (Reset),
    .exc_entry_i   (exc_entry),
    .exc_code_i    (exc_code),
    .pc_i          (bus.wr_PC),
    .eret_i        (eret),
    .mtc0_we_i     (mtc0_we),
    .cs_i          (bus.wr_cs),
    .sel_i         (bus.wr_sel),
    .wdata_i       (bus.wr_busB),
    .rdata_o       (cp0_rdata),
    .epc_pc_o      (epc_pc),
    .int_pending_o (int_pending)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      case (bus.wr_regToMul)
        RegToMulHi:   hi_q <= bus.wr_busA;
        RegToMulLo:   lo_q <= bus.wr_busA;
        RegToMulBoth: {hi_q, lo_q} <= bus.wr_mul_result;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rf_we     = commit & bus.wr_RegWr & (bus.wr_Rw != 5'd0);
    bus.rf_waddr  = bus.wr_valid ? bus.wr_Rw : 5'd0;
    bus.rf_wdata  = '0;
    if (bus.wr_valid) begin
      if (bus.wr_cp0Op == Cp0OpMfc0) bus.rf_wdata = cp0_rdata;
      else if (bus.wr_mulToReg)      bus.rf_wdata = bus.wr_mulRead ? hi_q : lo_q;
      else if (bus.wr_MemtoReg)      bus.rf_wdata = bus.wr_dout;
      else                           bus.rf_wdata = bus.wr_alu_result;
    end
    bus.exc_flush = exc_entry | eret;
    bus.exc_pc    = '0;
    if (exc_entry) bus.exc_pc = EXC_VECTOR[31:2];
    else if (eret) bus.exc_pc = epc_pc;
  end

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] epc_exp;

  localparam logic [29:0] VecPc = 30'h2FF0_00E0;

  always #5 clk = ~clk;

  wb_commit_if bus ();

  wb_commit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.wr_valid      = 1'b0;
    bus.wr_dout       = '0;
    bus.wr_alu_result = '0;
    bus.wr_Rw         = '0;
    bus.wr_RegWr      = 1'b0;
    bus.wr_MemtoReg   = 1'b0;
    bus.wr_busA       = '0;
    bus.wr_mul_result = '0;
    bus.wr_regToMul   = '0;
    bus.wr_mulToReg   = 1'b0;
    bus.wr_mulRead    = 1'b0;
    bus.wr_cs         = '0;
    bus.wr_sel        = '0;
    bus.wr_busB       = '0;
    bus.wr_cp0Op      = '0;
    bus.wr_PC         = '0;
  endtask

  // Each step starts at a negedge, applies one instruction and settles 1 ns
  task automatic alu(input logic [4:0] rw, input logic [31:0] v);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_RegWr = 1'b1; bus.wr_Rw = rw; bus.wr_alu_result = v;
    #1;
  endtask

  task automatic mfc0(input logic [4:0] cs, input logic [2:0] sel);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_RegWr = 1'b1; bus.wr_Rw = 5'd1;
    bus.wr_cp0Op = 3'b001; bus.wr_cs = cs; bus.wr_sel = sel;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [2:0] sel, input logic [31:0] v);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_cp0Op = 3'b010; bus.wr_cs = cs; bus.wr_sel = sel;
    bus.wr_busB = v;
    #1;
  endtask

  task automatic cop(input logic [2:0] o, input logic [29:0] pc);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_cp0Op = o; bus.wr_PC = pc;
    #1;
  endtask

  task automatic mfhilo(input logic hi);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_RegWr = 1'b1; bus.wr_Rw = 5'd3;
    bus.wr_mulToReg = 1'b1; bus.wr_mulRead = hi;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("idle_rf_we", {31'b0, bus.rf_we}, 32'd0);
    chk("idle_flush", {31'b0, bus.exc_flush}, 32'd0);
    chk("idle_wdata", bus.rf_wdata, 32'd0);

    mfc0(5'd12, 3'd0); chk("rst_status", bus.rf_wdata, 32'h0040_0000);
    mfc0(5'd14, 3'd0); chk("rst_epc", bus.rf_wdata, 32'd0);

    alu(5'd5, 32'h1234);
    chk("alu_we", {31'b0, bus.rf_we}, 32'd1);
    chk("alu_waddr", {27'b0, bus.rf_waddr}, 32'd5);
    chk("alu_wdata", bus.rf_wdata, 32'h1234);
    alu(5'd0, 32'h55);
    chk("r0_we", {31'b0, bus.rf_we}, 32'd0);

    // Load-data select
    alu(5'd7, 32'h1111); bus.wr_MemtoReg = 1'b1; bus.wr_dout = 32'hCAFE_F00D; #1;
    chk("load_wdata", bus.rf_wdata, 32'hCAFE_F00D);

    // MULT then MFHI/MFLO, MTLO
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_regToMul = 2'b11; bus.wr_mul_result = 64'h0000_0002_FFFF_FFFE;
    #1;
    chk("mult_flush", {31'b0, bus.exc_flush}, 32'd0);
    mfhilo(1'b1); chk("mfhi", bus.rf_wdata, 32'h2);
    mfhilo(1'b0); chk("mflo", bus.rf_wdata, 32'hFFFF_FFFE);
    @(negedge clk); clr();
    bus.wr_valid = 1'b1; bus.wr_regToMul = 2'b10; bus.wr_busA = 32'd7;
    #1;
    mfhilo(1'b0); chk("mtlo_lo", bus.rf_wdata, 32'd7);
    mfhilo(1'b1); chk("mtlo_hi", bus.rf_wdata, 32'h2);

    // SYSCALL entry
    cop(3'b011, 30'h40);
    chk("sys_flush", {31'b0, bus.exc_flush}, 32'd1);
    chk("sys_pc", {2'b0, bus.exc_pc}, {2'b0, VecPc});
    mfc0(5'd14, 3'd0); chk("sys_epc", bus.rf_wdata, 32'h100);
    mfc0(5'd13, 3'd0); chk("sys_cause", bus.rf_wdata, 32'h20);
    mfc0(5'd12, 3'd0); chk("sys_status", bus.rf_wdata, 32'h0040_0002);

    // Nested SYSCALL and BREAK while EXL=1
    cop(3'b011, 30'h80);
    chk("sys2_flush", {31'b0, bus.exc_flush}, 32'd1);
    mfc0(5'd14, 3'd0); chk("sys2_epc", bus.rf_wdata, 32'h100);
    cop(3'b101, 30'h90);
    chk("brk_pc", {2'b0, bus.exc_pc}, {2'b0, VecPc});
    mfc0(5'd13, 3'd0); chk("brk_cause", bus.rf_wdata, 32'h24);

    // ERET
    cop(3'b100, 30'h44);
    chk("eret_flush", {31'b0, bus.exc_flush}, 32'd1);
    chk("eret_pc", {2'b0, bus.exc_pc}, 32'h40);
    mfc0(5'd12, 3'd0); chk("eret_status", bus.rf_wdata, 32'h0040_0000);

    // MTC0 masks and select handling
    mtc0(5'd14, 3'd0, 32'h200);
    mfc0(5'd14, 3'd0); chk("mtc0_epc", bus.rf_wdata, 32'h200);
    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    mfc0(5'd12, 3'd0); chk("mtc0_status", bus.rf_wdata, 32'h0040_FF03);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    mfc0(5'd13, 3'd0); chk("mtc0_cause", bus.rf_wdata, 32'h324);
    mtc0(5'd12, 3'd0, 32'h8001);
    mfc0(5'd12, 3'd1); chk("sel1_read", bus.rf_wdata, 32'd0);
    mtc0(5'd12, 3'd1, 32'd0);
    mfc0(5'd12, 3'd0); chk("sel1_write", bus.rf_wdata, 32'h0040_8001);
    epc_exp = 32'h200;

`ifdef TIMER_INT_EN
    mtc0(5'd9, 3'd0, 32'd0);
    mtc0(5'd11, 3'd0, 32'd10);
    repeat (24) begin @(negedge clk); clr(); end
    alu(5'd4, 32'h99); bus.wr_PC = 30'h123; #1;
    chk("tmr_flush", {31'b0, bus.exc_flush}, 32'd1);
    chk("tmr_pc", {2'b0, bus.exc_pc}, {2'b0, VecPc});
    chk("tmr_we", {31'b0, bus.rf_we}, 32'd0);
    mfc0(5'd13, 3'd0); chk("tmr_cause", bus.rf_wdata, 32'h4000_8300);
    mfc0(5'd14, 3'd0); chk("tmr_epc", bus.rf_wdata, 32'h48C);
    mtc0(5'd11, 3'd0, 32'd1000);
    mfc0(5'd13, 3'd0); chk("tmr_clr", bus.rf_wdata, 32'h300);
    mtc0(5'd12, 3'd0, 32'h8001);
    epc_exp = 32'h48C;
`else
    mfc0(5'd9, 3'd0); chk("count_zero", bus.rf_wdata, 32'd0);
    mtc0(5'd11, 3'd0, 32'd5);
    mfc0(5'd11, 3'd0); chk("compare_zero", bus.rf_wdata, 32'd0);
    repeat (24) begin @(negedge clk); clr(); end
    alu(5'd4, 32'h99);
    chk("noint_flush", {31'b0, bus.exc_flush}, 32'd0);
    chk("noint_we", {31'b0, bus.rf_we}, 32'd1);
`endif

    // Invalid slot: nothing happens
    @(negedge clk); clr();
    bus.wr_cp0Op = 3'b011; bus.wr_RegWr = 1'b1; bus.wr_Rw = 5'd6; bus.wr_alu_result = 32'h77;
    bus.wr_PC = 30'h3FF;
    #1;
    chk("inv_flush", {31'b0, bus.exc_flush}, 32'd0);
    chk("inv_we", {31'b0, bus.rf_we}, 32'd0);
    chk("inv_wdata", bus.rf_wdata, 32'd0);
    mfc0(5'd14, 3'd0); chk("inv_epc", bus.rf_wdata, epc_exp);
    mfc0(5'd12, 3'd0); chk("inv_status", bus.rf_wdata, 32'h0040_8001);

    // Reset during ERET
    mtc0(5'd12, 3'd0, 32'h2);
    cop(3'b100, 30'h10);
    rst = 1'b1; #1;
    chk("rst_eret_flush", {31'b0, bus.exc_flush}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    mfc0(5'd12, 3'd0); chk("rst2_status", bus.rf_wdata, 32'h0040_0000);
    mfc0(5'd14, 3'd0); chk("rst2_epc", bus.rf_wdata, 32'd0);
    mfhilo(1'b1); chk("rst2_hi", bus.rf_wdata, 32'd0);

    @(negedge clk); clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Write-back/commit stage of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline-register outputs (wr_*).
- Drives the register-file write port and owns the HI/LO registers and a CP0 subset: Status, Cause, EPC, plus Count/Compare when the optional feature is compiled in.
- Raises the pipeline flush/redirect for SYSCALL, BREAK, ERET and the timer interrupt.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry address; exc_pc = EXC_VECTOR[31:2].

Ports:
Clk  in  1  clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
wr_valid  in  1  WB instruction valid; when 0 nothing commits and no event is raised.
wr_dout  in  32  load data.
wr_alu_result  in  32  ALU result.
wr_Rw  in  5  destination GPR.
wr_RegWr, wr_MemtoReg  in  1 each  GPR write enable; load-data select.
wr_busA  in  32  rs value, used by MTHI/MTLO.
wr_mul_result  in  64  multiplier product.
wr_regToMul  in  2  00 none, 01 HI<=busA, 10 LO<=busA, 11 {HI,LO}<=mul_result.
wr_mulToReg  in  1  GPR data comes from HI/LO.
wr_mulRead  in  1  1 = HI, 0 = LO.
wr_cs, wr_sel  in  5, 3  CP0 register number and select.
wr_busB  in  32  rt value, used by MTC0.
wr_cp0Op  in  3  000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET, 101 BREAK; others = none.
wr_PC  in  30  PC[31:2] of the WB instruction.
rf_we  out  1  GPR write enable.
rf_waddr  out  5  GPR write address.
rf_wdata  out  32  GPR write data.
exc_flush  out  1  flush all younger stages this cycle.
exc_pc  out  30  redirect target PC[31:2], valid when exc_flush=1.

Behaviour:
- Reset (synchronous, active-high): HI=LO=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, Count=0, Compare=0, count toggle=0. Outputs are combinational and read 0 while wr_valid=0.
- GPR data mux (combinational, zero latency):
  - MFC0: selected CP0 value.
  - else wr_mulToReg: HI or LO per wr_mulRead.
  - else wr_MemtoReg: wr_dout.
  - else wr_alu_result.
- rf_we = wr_valid & wr_RegWr & ~int_take & (wr_Rw != 0).
- Reads always return the pre-edge register value. MFHI straight after MULT in the same cycle is impossible; back-to-back commits see the updated HI/LO.
- HI/LO update at the edge per wr_regToMul when wr_valid & ~int_take.
- CP0 map (sel must be 0; any other number/sel reads 0 and ignores writes):
  - Count (9)
  - Compare (11)
  - Status (12): writable bits IM[15:8], EXL[1], IE[0]; BEV[22] read-only 1.
  - Cause (13): read-only except IP[9:8]; TI[30], IP7[15], ExcCode[6:2].
  - EPC (14): full 32-bit, written via MTC0.
- Interrupt condition: int_take = wr_valid & Status.IE & ~Status.EXL & Status.IM7 & Cause.IP7.
- Event priority within one cycle: int_take > SYSCALL/BREAK > ERET.
- Exception entry (interrupt, SYSCALL or BREAK):
  - exc_flush=1 and exc_pc=EXC_VECTOR[31:2] in the same cycle.
  - At the edge: if Status.EXL=0, EPC<={wr_PC,2'b00}; then EXL<=1.
  - ExcCode <= 0 (Int), 8 (Sys) or 9 (Bp).
  - The interrupted instruction does not commit.
- ERET: exc_flush=1, exc_pc=EPC[31:2] (pre-edge value); EXL<=0 at the edge.
- MTC0 and the hardware Count update in the same cycle: MTC0 wins.
- Reset asserted mid-operation overrides every pending update. exc_flush is still driven combinationally in that cycle; the core ignores it under Reset.

Optional Feature:
TIMER_INT_EN
- Defined:
  - Count increments every second Clk (toggle bit).
  - When the incremented Count equals Compare, Cause.TI and Cause.IP7 set to 1 and stay set.
  - MTC0 to Compare clears TI/IP7 and Count keeps counting.
  - MTC0 to Count loads the value and clears the toggle.
- Undefined: Count and Compare read 0, writes are ignored, TI/IP7 stay 0, and no interrupt can ever be taken.

Decomposition:
- Shared package/header wb_defs: CP0 register numbers, cp0Op encodings, regToMul encodings, ExcCode values, Status/Cause bit positions.
- One sub-module cp0_regs holds Status/Cause/EPC/Count/Compare, their read mux and exception/ERET update logic. wb_commit holds HI/LO, the GPR mux and event priority.

Test Plan:
- Reset, then ALU op with wr_RegWr=1, wr_Rw=5, alu=32'h1234 -> rf_we=1, waddr=5, wdata=32'h1234. Same with wr_Rw=0 -> rf_we=0.
- regToMul=11, mul=64'h0000_0002_FFFF_FFFE; next cycle mulToReg, mulRead=1 then 0 -> wdata 32'h2, then 32'hFFFF_FFFE. A following MTLO busA=7 -> LO read returns 7.
- SYSCALL at wr_PC=30'h0000_0040 -> exc_flush=1, exc_pc=30'h2FF000E0; next MFC0 EPC -> 32'h100; Cause[6:2]=8; Status.EXL=1. Then ERET -> exc_pc=30'h40 and EXL=0.
- Second SYSCALL while EXL=1 -> EPC unchanged, flush still asserted.
- TIMER_INT_EN: MTC0 Status=32'h8001, Compare=10 -> Count reaches 10 after about 20 cycles, then next valid instruction gets exc_flush=1, ExcCode=0, rf_we=0. MTC0 Compare clears IP7.
- wr_valid=0 with SYSCALL and RegWr set -> no flush, no write, no state change. Reset asserted during an ERET cycle -> Status returns to 32'h0040_0000.
